// File: rtl/seg7_score_display.sv
// Latches a packed BCD score and drives active-low seven-segment digits,
// blinking only the digits that changed for a fixed window after each update.
module seg7_score_display #(
  parameter int DIGITS      = 6,
  parameter int HALF_PERIOD = 12500000,
  parameter int TOGGLES     = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4*DIGITS-1:0]   bcd_in,
  input  logic                  bcd_valid,
  output logic                  bcd_ready,
  output logic [7*DIGITS-1:0]   hex_n,
  output logic                  busy
);

  localparam int PH_W = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam int TG_W = (TOGGLES > 1) ? $clog2(TOGGLES) : 1;
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(HALF_PERIOD - 1);
  localparam logic [TG_W-1:0] TG_LAST = TG_W'((TOGGLES > 0) ? TOGGLES - 1 : 0);

  typedef enum logic {IDLE, FLASH} state_t;

  state_t                 state_q;
  logic [4*DIGITS-1:0]    cur_q;
  logic [DIGITS-1:0]      chg_q, chg_d;
  logic                   vis_q;
  logic [PH_W-1:0]        phase_q;
  logic [TG_W-1:0]        tog_q;
  logic [7*DIGITS-1:0]    hex_q, hex_d;

  function automatic logic [6:0] dec(input logic [3:0] code);
    case (code)
      4'h0:    dec = 7'h40;
      4'h1:    dec = 7'h79;
      4'h2:    dec = 7'h24;
      4'h3:    dec = 7'h30;
      4'h4:    dec = 7'h19;
      4'h5:    dec = 7'h12;
      4'h6:    dec = 7'h02;
      4'h7:    dec = 7'h78;
      4'h8:    dec = 7'h00;
      4'h9:    dec = 7'h10;
      4'hF:    dec = 7'h7F;
      default: dec = 7'h3F;
    endcase
  endfunction

  always_comb begin
    chg_d = '0;
    hex_d = '1;
    for (int i = 0; i < DIGITS; i++) begin
      chg_d[i] = (bcd_in[4*i +: 4] != cur_q[4*i +: 4]);
      hex_d[7*i +: 7] = (chg_q[i] && !vis_q) ? 7'h7F : dec(cur_q[4*i +: 4]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cur_q   <= '1;
      chg_q   <= '0;
      vis_q   <= 1'b1;
      phase_q <= '0;
      tog_q   <= '0;
      hex_q   <= '1;
    end else begin
      hex_q <= hex_d;
      case (state_q)
        IDLE: begin
          if (bcd_valid) begin
            cur_q   <= bcd_in;
            chg_q   <= chg_d;
            phase_q <= '0;
            tog_q   <= '0;
            if ((chg_d != '0) && (TOGGLES > 0)) begin
              state_q <= FLASH;
              vis_q   <= 1'b0;
            end else begin
              vis_q   <= 1'b1;
            end
          end
        end
        FLASH: begin
          if (phase_q == PH_LAST) begin
            phase_q <= '0;
            vis_q   <= ~vis_q;
            tog_q   <= tog_q + TG_W'(1);
            // Last phase: the exit always leaves the digits lit, even for odd TOGGLES
            if (tog_q == TG_LAST) begin
              state_q <= IDLE;
              vis_q   <= 1'b1;
              chg_q   <= '0;
            end
          end else begin
            phase_q <= phase_q + PH_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bcd_ready = (state_q == IDLE);
  assign busy      = ~bcd_ready;
  assign hex_n     = hex_q;

endmodule
